// File: rtl/note_period_meter_pkg.sv
// Shared definitions for the note period meter and its note-player counterpart:
// one-hot FSM states, default pipeline offset and timeout, and the run range check.
package note_period_meter_pkg;

  localparam int NOTE_OFFSET  = 1;
  localparam int NOTE_TIMEOUT = 400;
  localparam int RUN_W        = 9;
  localparam int CODE_W       = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_MEASURE = 4'b0010,
    ST_CONFIRM = 4'b0100,
    ST_LOCKED  = 4'b1000
  } state_e;

  // A run maps back to a code only if it exceeds the player overhead and the code fits 8 bits.
  function automatic logic len_in_range(input logic [RUN_W-1:0] len, input int offset);
    int l;
    l = int'(len);
    return (l > offset) && ((l - offset) <= 255);
  endfunction

endpackage

// File: rtl/note_period_meter_run_counter.sv
// Edge detector and saturating run-length counter for the note input.
// len_o is the length of the run that an edge on this cycle terminates.
module note_run_counter
  import note_period_meter_pkg::*;
#(
  parameter int TIMEOUT = NOTE_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             note_i,
  output logic             edge_o,
  output logic [RUN_W-1:0] len_o,
  output logic             timeout_o
);

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  logic             note_prev_q;
  logic             first_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;

  // The first post-reset cycle only primes note_prev_q, so no edge can be reported then.
  assign edge_o    = !first_q && (note_i != note_prev_q);
  assign len_o     = run_q;
  // Fires once, on the cycle the counter would reach TIMEOUT; a coincident edge wins.
  assign timeout_o = !edge_o && (run_q == RUN_LAST);

  always_comb begin
    run_d = run_q;
    if (edge_o) begin
      run_d = RUN_W'(1);
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q     <= 1'b1;
      note_prev_q <= 1'b0;
      run_q       <= RUN_W'(1);
    end else begin
      first_q     <= 1'b0;
      note_prev_q <= note_i;
      run_q       <= run_d;
    end
  end

endmodule

// File: rtl/note_period_meter.sv
// Recovers the note-player period code from a square wave: locks once two consecutive
// half-periods agree, and flags silence when no edge arrives within TIMEOUT cycles.
module note_period_meter
  import note_period_meter_pkg::*;
#(
  parameter int OFFSET  = NOTE_OFFSET,
  parameter int TIMEOUT = NOTE_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              note,
  output logic [CODE_W-1:0] period,
  output logic              valid,
  output logic              silent,
  output logic [3:0]        state
);

  localparam logic [RUN_W-1:0] OFF_L = RUN_W'(OFFSET);

  logic             note_edge;
  logic [RUN_W-1:0] run_len;
  logic             timeout;

  note_run_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_run (
    .clk       (clk),
    .rst       (rst),
    .note_i    (note),
    .edge_o    (note_edge),
    .len_o     (run_len),
    .timeout_o (timeout)
  );

  state_e            state_q, state_d;
  logic [RUN_W-1:0]  ref_len_q, ref_len_d;
  logic [CODE_W-1:0] period_q, period_d;
  logic              valid_q, valid_d;
  logic              silent_q, silent_d;

  logic              len_ok;
  logic              len_match;
  logic [CODE_W-1:0] code;

  assign len_ok    = len_in_range(run_len, OFFSET);
  assign len_match = (run_len == ref_len_q);
  assign code      = CODE_W'(run_len - OFF_L);

  always_comb begin
    state_d   = state_q;
    ref_len_d = ref_len_q;
    period_d  = period_q;
    valid_d   = valid_q;
    silent_d  = silent_q;
    if (note_edge) begin
      silent_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (len_ok) begin
            ref_len_d = run_len;
            state_d   = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (len_ok && len_match) begin
            state_d  = ST_LOCKED;
            period_d = code;
            valid_d  = 1'b1;
          end else begin
            ref_len_d = run_len;
            state_d   = len_ok ? ST_CONFIRM : ST_MEASURE;
          end
        end
        ST_LOCKED: begin
          // The reference was range-checked on entry, so a match is always in range.
          if (!len_match) begin
            valid_d   = 1'b0;
            ref_len_d = run_len;
            state_d   = len_ok ? ST_CONFIRM : ST_MEASURE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end else if (timeout) begin
      state_d  = ST_IDLE;
      valid_d  = 1'b0;
      silent_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ref_len_q <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      silent_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      ref_len_q <= ref_len_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      silent_q  <= silent_d;
    end
  end

  assign period = period_q;
  assign valid  = valid_q;
  assign silent = silent_q;
  assign state  = state_q;

endmodule

// File: tb/tb_note_period_meter.sv
// Directed bench for note_period_meter: a run-history model checked every cycle,
// plus literal expectations for lock latency, timeout, relock, range limits and reset.
module tb_note_period_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       note = 1'b0;
  logic [7:0] period;
  logic       valid;
  logic       silent;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  note_period_meter dut (
    .clk    (clk),
    .rst    (rst),
    .note   (note),
    .period (period),
    .valid  (valid),
    .silent (silent),
    .state  (state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks the completed half-period lengths since the last sync.
  int       cyc = 0;
  bit       m_init = 0;
  bit       m_first, m_prev, m_synced, m_locked, m_valid, m_silent;
  int       m_cand, m_last_edge;
  int       m_period;

  function automatic int m_state();
    if (!m_synced)    return 1;
    else if (m_locked) return 8;
    else if (m_cand < 0) return 2;
    else return 4;
  endfunction

  always @(posedge clk) begin : model
    int  since, len;
    bit  ok, edge_m;
    cyc++;
    if (rst) begin
      m_init = 1; m_first = 1; m_last_edge = cyc;
      m_synced = 0; m_locked = 0; m_cand = -1;
      m_period = 0; m_valid = 0; m_silent = 1;
    end else if (m_init) begin
      edge_m = !m_first && (note != m_prev);
      m_prev = note;
      m_first = 0;
      since = cyc - m_last_edge;
      if (edge_m) begin
        len = (since > 400) ? 400 : since;
        m_last_edge = cyc;
        ok = (len > 1) && (len - 1 <= 255);
        m_silent = 0;
        if (!m_synced) begin
          m_synced = 1; m_cand = -1;
        end else if (m_locked) begin
          if (len != m_cand) begin
            m_locked = 0; m_valid = 0; m_cand = ok ? len : -1;
          end
        end else if (m_cand >= 0 && ok && len == m_cand) begin
          m_locked = 1; m_valid = 1; m_period = len - 1;
        end else begin
          m_cand = ok ? len : -1;
        end
      end else if (since == 399) begin
        m_synced = 0; m_locked = 0; m_cand = -1; m_valid = 0; m_silent = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_state", int'(state), m_state());
      check("model_period", int'(period), m_period);
      check("model_valid", int'(valid), int'(m_valid));
      check("model_silent", int'(silent), int'(m_silent));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each toggle ends the current run; the next toggle comes n cycles later.
  task automatic toggle_runs(input int count, input int n);
    repeat (count) begin
      note = ~note;
      cycles(n);
    end
  endtask

  task automatic expect_out(input string tag, input int p, input int v, input int s, input int st);
    check({tag, "_period"}, int'(period), p);
    check({tag, "_valid"}, int'(valid), v);
    check({tag, "_silent"}, int'(silent), s);
    check({tag, "_state"}, int'(state), st);
  endtask

  initial begin
    rst = 1'b1;
    note = 1'b0;
    cycles(3);
    expect_out("reset", 0, 0, 1, 1);
    rst = 1'b0;
    cycles(2);

    // Toggle every 10 cycles: valid appears right after the 3rd edge.
    toggle_runs(2, 10);
    check("lat_before_valid", int'(valid), 0);
    check("lat_before_state", int'(state), 4);
    note = ~note;
    cycles(1);
    check("lat_after_valid", int'(valid), 1);
    cycles(9);
    toggle_runs(1, 10);
    expect_out("lock10", 9, 1, 0, 8);

    // Silence after lock.
    cycles(401);
    expect_out("silence", 9, 0, 1, 1);

    // Relock at 10, then switch to half-period 20.
    toggle_runs(4, 10);
    expect_out("relock10", 9, 1, 0, 8);
    toggle_runs(2, 20);
    check("switch20_valid", int'(valid), 0);
    check("switch20_state", int'(state), 4);
    toggle_runs(1, 20);
    expect_out("lock20", 19, 1, 0, 8);

    // Too-short then too-long runs never lock.
    toggle_runs(10, 1);
    check("short_state", int'(state), 2);
    check("short_valid", int'(valid), 0);
    toggle_runs(4, 300);
    expect_out("long", 19, 0, 0, 2);

    // Edge exactly when the run would hit TIMEOUT: out-of-range run, not silence.
    toggle_runs(1, 399);
    toggle_runs(1, 5);
    expect_out("edge_vs_timeout", 19, 0, 0, 2);

    // Largest code, then one beyond it.
    toggle_runs(4, 256);
    expect_out("code255", 255, 1, 0, 8);
    toggle_runs(3, 257);
    expect_out("code256", 255, 0, 0, 2);

    // Reset while locked.
    toggle_runs(4, 10);
    expect_out("prereset", 9, 1, 0, 8);
    rst = 1'b1;
    cycles(1);
    expect_out("midreset", 0, 0, 1, 1);
    rst = 1'b0;
    cycles(2);

    // Tone source for period code 50 (half-period 51 cycles).
    toggle_runs(4, 51);
    expect_out("loop50", 50, 1, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
